// File: rtl/instr_packer.sv
// instr_packer
//   Packs opcode + operand (register index or imm5) into a 9-bit instruction
//   word, buffers words in a small registered FIFO and streams them into
//   instruction memory at auto-incrementing addresses starting at base_addr.
//
//   Instruction word: instr[8:5] = opcode
//                     instr[4:0] = in_sel ? in_imm[4:0] : {2'b00, in_reg}
//
//   Handshakes (both ports use the same rule): a transfer happens on a rising
//   clock edge where valid and ready are both high. in_valid/in_ready moves a
//   word into the FIFO; mem_we/mem_ready moves the FIFO head into memory.
//   Neither side's ready is allowed to depend on its own valid.
//
//   Optional feature macro: INSTR_PACKER_IMM_CHECK_EN
//     defined   -> immediates with in_imm[7:5] != 0 set the sticky err_imm flag
//                  (the word is still written, truncated to imm5)
//     undefined -> no range check, err_imm is tied low
//
//   state_dbg exposes the FSM state (0 IDLE, 1 RUN, 2 FLUSH).

module instr_packer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [ADDR_W-1:0]          base_addr,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0]                 in_opcode,
    input  logic                       in_sel,
    input  logic [2:0]                 in_reg,
    input  logic [7:0]                 in_imm,
    input  logic                       in_last,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [8:0]                 mem_wdata,
    input  logic                       mem_ready,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       wrapped,
    output logic                       done,
    output logic                       err_imm,
    output logic [1:0]                 state_dbg
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t state, state_nxt;

    // FIFO entry: {last, instr[8:0]}
    logic [9:0]       fifo_mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             start_take;
    logic [9:0]       head;
    logic             head_last;
    logic [8:0]       packed_word;

    assign count      = wr_ptr - rd_ptr;
    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign push       = in_valid && in_ready;
    assign pop        = mem_we && mem_ready;
    assign start_take = (state == IDLE) && start;
    assign head       = fifo_mem[rd_ptr[PTR_W-1:0]];
    assign head_last  = head[9];
    assign packed_word = {in_opcode, (in_sel ? in_imm[4:0] : {2'b00, in_reg})};

    assign mem_wdata  = head[8:0];
    assign fifo_count = count;
    assign state_dbg  = state;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next-state: a program runs from start to the write of its last word
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (push && in_last) state_nxt = FLUSH;
            FLUSH:   if (pop && head_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: accept only while running with space, write whenever buffered
    always_comb begin
        in_ready = (state == RUN) && !full;
        mem_we   = !empty && (state != IDLE);
    end

    // FIFO storage and pointers; start discards anything left over
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) fifo_mem[i] <= '0;
        end else if (start_take) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr[PTR_W-1:0]] <= {in_last, packed_word};
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Write address counter and sticky wrap flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr <= '0;
            wrapped  <= 1'b0;
        end else if (start_take) begin
            mem_addr <= base_addr;
            wrapped  <= 1'b0;
        end else if (pop) begin
            mem_addr <= mem_addr + 1'b1;
            if (mem_addr == {ADDR_W{1'b1}}) wrapped <= 1'b1;
        end
    end

    // One-cycle completion pulse after the last word has been written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) done <= 1'b0;
        else        done <= pop && head_last;
    end

`ifdef INSTR_PACKER_IMM_CHECK_EN
    // Sticky flag for accepted immediates that do not fit in imm5
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                  err_imm <= 1'b0;
        else if (start_take)                         err_imm <= 1'b0;
        else if (push && in_sel && (|in_imm[7:5]))   err_imm <= 1'b1;
    end
`else
    // Upper immediate bits are silently truncated in this build
    logic unused_imm_hi;
    assign unused_imm_hi = ^in_imm[7:5];
    assign err_imm       = 1'b0;
`endif

endmodule
